// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Purpose : MMU width codes, arbiter state encoding and watchdog sizing helper.
// Rev     : 1.0
// ============================================================================
package mem_port_arbiter_pkg;

    localparam logic [1:0] MMU_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] MMU_WIDTH_HALF = 2'd1;
    localparam logic [1:0] MMU_WIDTH_WORD = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_BUSY = 2'd1,
        ARB_DM_BUSY = 2'd2,
        ARB_IF_DROP = 2'd3
    } arb_state_t;

    // Counter must hold values 0 .. limit-1.
    function automatic int stall_cnt_width(input int limit);
        return (limit > 2) ? $clog2(limit) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one MMU port between instruction fetch and data access,
//           one registered transaction at a time, with a stall watchdog.
//           Define MEM_ARB_FAIR_EN to alternate priority after a data grant.
// Rev     : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STALL_LIMIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_write,
    input  logic              dm_signed,
    input  logic [1:0]        dm_width,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_err,
    input  logic              mmu_mem_ready,
    input  logic [DATA_W-1:0] mmu_data_out,
    output logic              mmu_write_enable,
    output logic              mmu_read_enable,
    output logic              mmu_mem_signed_read,
    output logic [1:0]        mmu_mem_data_width,
    output logic [ADDR_W-1:0] mmu_address,
    output logic [DATA_W-1:0] mmu_data_in
);

    localparam int              CNT_W      = stall_cnt_width(STALL_LIMIT);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STALL_LIMIT - 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_if_ok;
    logic w_dm_ok;
    logic w_pick_if;
    logic w_pick_dm;
    logic w_stall;

    // A port acked this cycle is still holding its old request; skip it once.
    assign w_if_ok = if_req && !if_flush && !if_ack;
    assign w_dm_ok = dm_req && !dm_ack;

`ifdef MEM_ARB_FAIR_EN
    logic r_last_dm;
    assign w_pick_if = w_if_ok && (!w_dm_ok || r_last_dm);
`else
    assign w_pick_if = w_if_ok && !w_dm_ok;
`endif
    assign w_pick_dm = w_dm_ok && !w_pick_if;

    assign w_stall = (STALL_LIMIT != 0) && (r_cnt == c_cnt_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state             <= ARB_IDLE;
            r_cnt               <= '0;
            if_ack              <= 1'b0;
            if_rdata            <= '0;
            dm_ack              <= 1'b0;
            dm_rdata            <= '0;
            stall_err           <= 1'b0;
            mmu_write_enable    <= 1'b0;
            mmu_read_enable     <= 1'b0;
            mmu_mem_signed_read <= 1'b0;
            mmu_mem_data_width  <= '0;
            mmu_address         <= '0;
            mmu_data_in         <= '0;
`ifdef MEM_ARB_FAIR_EN
            r_last_dm           <= 1'b0;
`endif
        end else begin
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            stall_err <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    r_cnt <= '0;
                    if (w_pick_dm) begin
                        r_state             <= ARB_DM_BUSY;
                        mmu_write_enable    <= dm_write;
                        mmu_read_enable     <= !dm_write;
                        mmu_mem_signed_read <= dm_signed;
                        mmu_mem_data_width  <= dm_width;
                        mmu_address         <= dm_addr;
                        mmu_data_in         <= dm_wdata;
`ifdef MEM_ARB_FAIR_EN
                        r_last_dm           <= 1'b1;
`endif
                    end else if (w_pick_if) begin
                        r_state             <= ARB_IF_BUSY;
                        mmu_write_enable    <= 1'b0;
                        mmu_read_enable     <= 1'b1;
                        mmu_mem_signed_read <= 1'b0;
                        mmu_mem_data_width  <= MMU_WIDTH_WORD;
                        mmu_address         <= if_addr;
                        mmu_data_in         <= '0;
`ifdef MEM_ARB_FAIR_EN
                        r_last_dm           <= 1'b0;
`endif
                    end
                end
                default: begin
                    // Completion takes precedence over a watchdog expiring in the same cycle.
                    if (mmu_mem_ready) begin
                        mmu_write_enable <= 1'b0;
                        mmu_read_enable  <= 1'b0;
                        r_state          <= ARB_IDLE;
                        if (r_state == ARB_DM_BUSY) begin
                            dm_ack <= 1'b1;
                            if (mmu_read_enable) begin
                                dm_rdata <= mmu_data_out;
                            end
                        end else if (r_state == ARB_IF_BUSY && !if_flush) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mmu_data_out;
                        end
                    end else if (w_stall) begin
                        mmu_write_enable <= 1'b0;
                        mmu_read_enable  <= 1'b0;
                        stall_err        <= 1'b1;
                        r_state          <= ARB_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_state == ARB_IF_BUSY && if_flush) begin
                            r_state <= ARB_IF_DROP;
                        end
                    end
                end
            endcase
        end
    end

    a_dm_req_held: assert property (@(posedge clk) disable iff (reset)
        (r_state == ARB_DM_BUSY) |-> dm_req);

endmodule
`default_nettype wire
